// File: rtl/lifo_pkg.sv
// Shared types and helpers for the LIFO stack and its readers.
package lifo_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_FLUSH = 2'd2
    } rd_state_e;

    // Bits needed to hold the values 0..n, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lifo_out_stage.sv
// Single-entry valid/ready output register carrying data plus a last flag.
module lifo_out_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  free
);

    // Free when empty or when the held beat leaves this cycle.
    assign free = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the data register is reset as well, so out_data reads 0 rather than X after reset.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            // NOTE: non-blocking assignments, so every register here samples its pre-edge inputs.
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lifo_burst_reader.sv
// Pops a requested burst from the LIFO stack onto a valid/ready stream.
// Optional stall abort is enabled by defining LIFO_RD_ABORT_EN.
module lifo_burst_reader
    import lifo_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int MAX_BURST    = 16,
    parameter  int ABORT_CYCLES = 8,
    localparam int CNT_W        = cnt_width(MAX_BURST)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CNT_W-1:0]      req_count,
    input  logic [DATA_WIDTH-1:0] stk_top,
    input  logic                  stk_empty,
    output logic                  stk_pop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    if (MAX_BURST < 1 || ABORT_CYCLES < 1) begin : g_bad_params
        $fatal(1, "lifo_burst_reader: MAX_BURST and ABORT_CYCLES must be >= 1");
    end

    rd_state_e        state;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] req_sat;
    logic             stage_free;
    logic             capture;
    logic             beat_done;
    logic             abort_hit;

    assign req_ready = (state == RD_IDLE);
    assign busy      = (state != RD_IDLE);
    assign req_sat   = (req_count > CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : req_count;
    assign capture   = (state == RD_RUN) && !stk_empty && (remaining != '0) && stage_free;
    assign stk_pop   = capture;
    assign beat_done = out_valid && out_ready;

    lifo_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (capture),
        .load_data (stk_top),
        .load_last (remaining == CNT_W'(1)),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .free      (stage_free)
    );

`ifdef LIFO_RD_ABORT_EN
    localparam int STALL_W = cnt_width(ABORT_CYCLES);

    logic [STALL_W-1:0] stall_cnt;
    logic               stall_inc;
    logic               abort_flag;

    assign stall_inc = (state == RD_RUN) && stk_empty && (remaining != '0);
    assign abort_hit = stall_inc && (stall_cnt == STALL_W'(ABORT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            abort_flag <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            aborted <= 1'b0;
            if (capture || state != RD_RUN) begin
                stall_cnt <= '0;
            end else if (stall_inc) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
            // A pending beat still drains first; the abort is reported with its done.
            if (abort_hit) begin
                if (out_valid && !out_ready) begin
                    abort_flag <= 1'b1;
                end else begin
                    aborted <= 1'b1;
                end
            end else if (state == RD_FLUSH && beat_done) begin
                aborted    <= abort_flag;
                abort_flag <= 1'b0;
            end
        end
    end
`else
    assign abort_hit = 1'b0;
    assign aborted   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RD_IDLE;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RD_IDLE: begin
                    if (req_valid) begin
                        if (req_sat == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= RD_RUN;
                            remaining <= req_sat;
                        end
                    end
                end
                RD_RUN: begin
                    if (capture) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= RD_FLUSH;
                        end
                    end else if (abort_hit) begin
                        remaining <= '0;
                        if (out_valid && !out_ready) begin
                            state <= RD_FLUSH;
                        end else begin
                            state <= RD_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                RD_FLUSH: begin
                    if (beat_done) begin
                        state <= RD_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule
